// File: rtl/cg_rvarch_pkg.sv
// Shared rvarch register-file types and defaults.
package cg_rvarch_pkg;

  localparam int unsigned RV_DATA_WIDTH = 32;
  localparam int unsigned RV_DATA_NUM   = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } regfile_state_e;

  // Address width for n entries; at least one bit.
  function automatic int unsigned calc_aw(int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cg_rvarch_regfile_mp_if.sv
// Decode/issue and writeback bus of the multi-ported register file.
interface cg_rvarch_regfile_mp_if
  import cg_rvarch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RV_DATA_WIDTH,
  parameter int unsigned DATA_NUM   = RV_DATA_NUM,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1
);
  localparam int unsigned AW = calc_aw(DATA_NUM);

  logic [NUM_RD*AW-1:0]         i_rs_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] o_rs_data;
  logic [NUM_RD-1:0]            o_rs_busy;
  logic [NUM_WR-1:0]            i_rd_we;
  logic [NUM_WR*AW-1:0]         i_rd_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] i_rd_data;
  logic                         i_alloc_vld;
  logic [AW-1:0]                i_alloc_addr;
  logic                         o_ready;

  modport slave (
    input  i_rs_addr, i_rd_we, i_rd_addr, i_rd_data, i_alloc_vld, i_alloc_addr,
    output o_rs_data, o_rs_busy, o_ready
  );

  modport master (
    output i_rs_addr, i_rd_we, i_rd_addr, i_rd_data, i_alloc_vld, i_alloc_addr,
    input  o_rs_data, o_rs_busy, o_ready
  );

endinterface

// File: rtl/cg_rvarch_scoreboard.sv
// Busy-bit scoreboard: writes clear, allocations set; allocation wins on conflict.
module cg_rvarch_scoreboard
  import cg_rvarch_pkg::*;
#(
  parameter int unsigned DATA_NUM = RV_DATA_NUM,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned AW       = calc_aw(DATA_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_vld_i,
  input  logic [AW-1:0]        alloc_addr_i,
  input  logic [NUM_WR-1:0]    clr_vld_i,
  input  logic [NUM_WR*AW-1:0] clr_addr_i,
  output logic [DATA_NUM-1:0]  busy_o
);

  logic [DATA_NUM-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (clr_vld_i[j]) busy_d[clr_addr_i[j*AW +: AW]] = 1'b0;
    end
    if (alloc_vld_i) busy_d[alloc_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/cg_rvarch_regfile_mp.sv
// Multi-ported architectural register file with post-reset clear sequencer,
// optional write bypass, optional hardwired zero register and busy scoreboard.
module cg_rvarch_regfile_mp
  import cg_rvarch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RV_DATA_WIDTH,
  parameter int unsigned DATA_NUM   = RV_DATA_NUM,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  cg_rvarch_regfile_mp_if.slave bus
);

  localparam int unsigned AW = calc_aw(DATA_NUM);

  regfile_state_e  state_q;
  logic [AW-1:0]   clr_idx_q;
  logic            ready_q;

  logic [DATA_WIDTH-1:0] mem_q [DATA_NUM];

  logic [NUM_WR-1:0]            we_eff;
  logic                         alloc_eff;
  logic [DATA_NUM-1:0]          busy;
  logic [NUM_RD*DATA_WIDTH-1:0] rs_data;
  logic [NUM_RD-1:0]            rs_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_idx_q <= clr_idx_q + AW'(1);
          if (clr_idx_q == AW'(DATA_NUM - 1)) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: ;
      endcase
    end
  end

  // Writes and allocations only count once READY; address 0 is dropped when hardwired.
  always_comb begin
    we_eff = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      we_eff[j] = ready_q && bus.i_rd_we[j] &&
                  !(ZERO_REG && (bus.i_rd_addr[j*AW +: AW] == '0));
    end
    alloc_eff = ready_q && bus.i_alloc_vld && !(ZERO_REG && (bus.i_alloc_addr == '0));
  end

  // No per-entry reset: storage is zeroed by the clear sequencer instead.
  always_ff @(posedge i_clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_idx_q] <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (we_eff[j]) mem_q[bus.i_rd_addr[j*AW +: AW]] <= bus.i_rd_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  cg_rvarch_scoreboard #(
    .DATA_NUM (DATA_NUM),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_scoreboard (
    .clk_i        (i_clk),
    .rst_ni       (i_rst_n),
    .alloc_vld_i  (alloc_eff),
    .alloc_addr_i (bus.i_alloc_addr),
    .clr_vld_i    (we_eff),
    .clr_addr_i   (bus.i_rd_addr),
    .busy_o       (busy)
  );

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0]         ra;
      logic [DATA_WIDTH-1:0] d;
      logic                  b;
      ra = bus.i_rs_addr[k*AW +: AW];
      d  = mem_q[ra];
      b  = busy[ra];
      if (BYPASS) begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (we_eff[j] && (bus.i_rd_addr[j*AW +: AW] == ra)) begin
            d = bus.i_rd_data[j*DATA_WIDTH +: DATA_WIDTH];
            b = 1'b0;
          end
        end
      end
      if (!ready_q || (ZERO_REG && (ra == '0))) begin
        d = '0;
        b = 1'b0;
      end
      rs_data[k*DATA_WIDTH +: DATA_WIDTH] = d;
      rs_busy[k] = b;
    end
  end

  assign bus.o_rs_data = rs_data;
  assign bus.o_rs_busy = rs_busy;
  assign bus.o_ready   = ready_q;

endmodule
